// File: rtl/bch_pkg.sv
// Shared BCH(63,51) code dimensions and the transmit scheduler state encoding.
package bch_pkg;

  localparam int unsigned K = 51;
  localparam int unsigned N = 63;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: on contention the source not granted last time wins.
module rr_arb2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  output logic gnt_valid_o,
  output logic gnt_o
);

  always_comb begin
    gnt_valid_o = valid0_i | valid1_i;
    if (valid0_i && valid1_i) begin
      gnt_o = ~last_grant_i;
    end else begin
      gnt_o = valid1_i;
    end
  end

endmodule

// File: rtl/bch_tx_sched.sv
// Shares one bit-serial BCH encoder between two message sources: accepts whole
// K-bit messages, shifts them MSB-first, then idles for the N-K parity cycles.
module bch_tx_sched #(
  parameter int unsigned K  = bch_pkg::K,
  parameter int unsigned N  = bch_pkg::N,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [K-1:0]  req0_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [K-1:0]  req1_data,
  output logic          enc_valid,
  input  logic          enc_ready,
  output logic          enc_data,
  output logic          enc_sof,
  output logic          enc_eof,
  output logic          cur_src,
  output logic          busy,
  output logic [CW-1:0] frames0,
  output logic [CW-1:0] frames1
);

  import bch_pkg::*;

  localparam int unsigned BW = $clog2(K);
  localparam int unsigned GW = $clog2(N - K + 1);

  state_e          state_q;
  logic [K-1:0]    sr_q;
  logic [BW-1:0]   bitcnt_q;
  logic [GW-1:0]   gapcnt_q;
  logic            last_grant_q;
  logic            cur_src_q;
  logic [CW-1:0]   frames0_q;
  logic [CW-1:0]   frames1_q;

  logic gnt_valid;
  logic gnt;
  logic hs;
  logic last_bit;

  rr_arb2 u_arb (
    .valid0_i     (req0_valid),
    .valid1_i     (req1_valid),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_o        (gnt)
  );

  // A grant in IDLE is always a handshake: ready is only raised for a valid source.
  assign hs         = !rst && (state_q == IDLE) && gnt_valid;
  assign req0_ready = hs && !gnt;
  assign req1_ready = hs && gnt;

  assign last_bit  = (bitcnt_q == BW'(K - 1));
  assign enc_valid = (state_q == SHIFT);
  assign enc_data  = enc_valid && sr_q[K-1];
  assign enc_sof   = enc_valid && (bitcnt_q == '0);
  assign enc_eof   = enc_valid && last_bit;
  assign busy      = (state_q != IDLE);
  assign cur_src   = cur_src_q;
  assign frames0   = frames0_q;
  assign frames1   = frames1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      bitcnt_q     <= '0;
      gapcnt_q     <= '0;
      last_grant_q <= 1'b1;
      cur_src_q    <= 1'b0;
      frames0_q    <= '0;
      frames1_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hs) begin
            sr_q         <= gnt ? req1_data : req0_data;
            cur_src_q    <= gnt;
            last_grant_q <= gnt;
            bitcnt_q     <= '0;
            state_q      <= SHIFT;
          end
        end
        SHIFT: begin
          if (enc_ready) begin
            sr_q     <= {sr_q[K-2:0], 1'b0};
            bitcnt_q <= bitcnt_q + 1'b1;
            if (last_bit) begin
              if (cur_src_q) begin
                frames1_q <= frames1_q + CW'(1);
              end else begin
                frames0_q <= frames0_q + CW'(1);
              end
              gapcnt_q <= '0;
              state_q  <= GAP;
            end
          end
        end
        GAP: begin
          if (gapcnt_q == GW'(N - K - 1)) begin
            state_q <= IDLE;
          end else begin
            gapcnt_q <= gapcnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_tx_sched.sv
// Scoreboard bench for bch_tx_sched: expected frames are queued as messages are
// offered and compared against the reassembled serial stream.
module tb_bch_tx_sched;

  localparam int K  = 51;
  localparam int N  = 63;
  localparam int CW = 16;

  typedef struct packed {
    logic         src;
    logic [K-1:0] data;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          req0_valid, req0_ready;
  logic [K-1:0]  req0_data;
  logic          req1_valid, req1_ready;
  logic [K-1:0]  req1_data;
  logic          enc_valid, enc_ready, enc_data, enc_sof, enc_eof;
  logic          cur_src, busy;
  logic [CW-1:0] frames0, frames1;

  bch_tx_sched #(.K(K), .N(N), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .enc_valid  (enc_valid),
    .enc_ready  (enc_ready),
    .enc_data   (enc_data),
    .enc_sof    (enc_sof),
    .enc_eof    (enc_eof),
    .cur_src    (cur_src),
    .busy       (busy),
    .frames0    (frames0),
    .frames1    (frames1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  exp_t sb[$];
  int   hs_cyc[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Serial stream monitor, sampled well after the negedge input updates.
  int           idx = 0;
  int           ferr = 0;
  int           hold_err = 0;
  bit           stall = 0;
  logic [2:0]   held;
  logic [K-1:0] word;
  exp_t         e;

  always @(negedge clk) begin
    #2;
    if (rst || !enc_valid) begin
      idx = 0; ferr = 0; stall = 0;
    end else begin
      if (stall && ({enc_data, enc_sof, enc_eof} !== held)) hold_err++;
      if (enc_ready) begin
        if (enc_sof !== (idx == 0)) ferr++;
        if (enc_eof !== (idx == K - 1)) ferr++;
        word = {word[K-2:0], enc_data};
        idx++;
        stall = 0;
        if (idx == K) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            chk("frame_data", 64'(word), 64'(e.data));
            chk("frame_src", 64'(cur_src), 64'(e.src));
            chk("framing", 64'(ferr), 64'd0);
          end
          idx = 0; ferr = 0;
        end
      end else begin
        stall = 1;
        held  = {enc_data, enc_sof, enc_eof};
      end
    end
  end

  task automatic send(input bit src, input logic [K-1:0] d, output int waits);
    waits = 0;
    if (src) begin req1_valid = 1'b1; req1_data = d; end
    else     begin req0_valid = 1'b1; req0_data = d; end
    #1;
    while (!(src ? req1_ready : req0_ready) && waits < 500) begin
      @(negedge clk); #1;
      waits++;
    end
    if (waits >= 500) chk("hs_timeout", 64'd1, 64'd0);
    else hs_cyc.push_back(cyc);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input bit src, input logic [K-1:0] d);
    exp_t x;
    x.src  = src;
    x.data = d;
    sb.push_back(x);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  logic [K-1:0] c [4];
  logic [K-1:0] d;
  int w, w0, w1;

  initial begin
    rst = 1'b1; enc_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    repeat (3) @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_outs", 64'({enc_valid, enc_sof, enc_eof, enc_data, busy, cur_src,
                         req0_ready, req1_ready}), 64'd0);
    chk("rst_frames", 64'({frames0, frames1}), 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Single source 0 frame with exact cycle positions.
    d = 51'h4_2576_8682_D556;
    push(1'b0, d);
    send(1'b0, d, w);
    req0_valid = 1'b0;
    chk("rdy_first_idle", 64'(w), 64'd0);
    chk("sof_t1", 64'({enc_valid, enc_sof, enc_data}), 64'b111);
    repeat (50) @(negedge clk);
    chk("eof_tK", 64'({enc_valid, enc_eof, enc_data}), 64'b110);
    repeat (12) @(negedge clk);
    chk("gap_last", 64'({enc_valid, busy}), 64'b01);
    @(negedge clk);
    chk("idle_t64", 64'({busy, cur_src}), 64'd0);
    chk("frames0_t1", 64'(frames0), 64'd1);

    // Contention from reset: 0,1,0,1 with 64-cycle spacing.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hs_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      c[i] = K'({$urandom(), $urandom()});
      push(1'(i % 2), c[i]);
    end
    fork
      begin send(1'b0, c[0], w0); send(1'b0, c[2], w0); req0_valid = 1'b0; end
      begin send(1'b1, c[1], w1); send(1'b1, c[3], w1); req1_valid = 1'b0; end
    join
    wait_drain();
    chk("hs_count", 64'(hs_cyc.size()), 64'd4);
    for (int i = 0; i + 1 < hs_cyc.size(); i++)
      chk("hs_spacing", 64'(hs_cyc[i+1] - hs_cyc[i]), 64'd64);
    chk("frames_rr", 64'({frames0, frames1}), {32'd0, 16'd2, 16'd2});

    // Encoder back-pressure for 5 cycles at bit 20.
    d = K'({$urandom(), $urandom()});
    push(1'b0, d);
    send(1'b0, d, w);
    req0_valid = 1'b0;
    repeat (20) @(negedge clk);
    enc_ready = 1'b0;
    repeat (5) @(negedge clk);
    enc_ready = 1'b1;
    repeat (29) @(negedge clk);
    chk("no_eof_early", 64'(enc_eof), 64'd0);
    @(negedge clk);
    chk("eof_stall", 64'({enc_valid, enc_eof}), 64'b11);
    wait_drain();
    chk("hold", 64'(hold_err), 64'd0);
    chk("frames0_stall", 64'(frames0), 64'd3);

    // Reset in the middle of a source 1 frame.
    d = K'({$urandom(), $urandom()});
    push(1'b1, d);
    send(1'b1, d, w);
    req1_valid = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    d = K'({$urandom(), $urandom()});
    req0_valid = 1'b1; req0_data = d;
    #1;
    chk("rdy_in_rst", 64'(req0_ready), 64'd0);
    void'(sb.pop_back());
    @(negedge clk);
    chk("rst_mid_outs", 64'({enc_valid, busy}), 64'd0);
    chk("rst_mid_frames", 64'({frames0, frames1}), 64'd0);
    rst = 1'b0;
    push(1'b0, d);
    send(1'b0, d, w);
    req0_valid = 1'b0;
    chk("post_rst_sof", 64'({enc_valid, enc_sof, enc_data}), 64'({2'b11, d[K-1]}));
    wait_drain();
    chk("frames_post_rst", 64'({frames0, frames1}), {32'd0, 16'd1, 16'd0});

    // Counter wrap from all-ones.
    force dut.frames0_q = 16'hFFFF;
    #1;
    release dut.frames0_q;
    d = K'({$urandom(), $urandom()});
    push(1'b0, d);
    send(1'b0, d, w);
    req0_valid = 1'b0;
    wait_drain();
    chk("frames0_wrap", 64'(frames0), 64'd0);

    // Random messages alternating sources.
    for (int i = 0; i < 10; i++) begin
      d = K'({$urandom(), $urandom()});
      push(1'(i % 2), d);
      send(1'(i % 2), d, w);
      req0_valid = 1'b0; req1_valid = 1'b0;
    end
    wait_drain();
    chk("frames_loop", 64'({frames0, frames1}), {32'd0, 16'd5, 16'd5});
    chk("sb_drain", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
